pipe_optop_trk: RTL and testbench
=================================

# pipe_optop_trk

R-stage speculative OPTOP and PC-offset tracker. It feeds the OPTOP/PC pipe datapath directly upstream: it produces `optop_shft_r`, `pc_offset_r`, `optop_sel_e`, `optop_enable` and `pc_enable`. It accumulates each dispatched instruction group's stack delta and byte length, and recovers from flushes and trap-frame building by reloading from the architectural OPTOP.

## Interface
Parameters:
- `DELTA_W`, default 4: width of signed per-group stack delta in words (range −8..+7).
- `TRAP_OPTOP`, default 32'h003ffffc: OPTOP value at reset.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `dec_valid_r`  in  1  decoded group valid at R.
- `dec_delta_r`  in  DELTA_W  signed net words pushed by the group; positive means push.
- `dec_len_r`  in  3  bytes consumed by the group (0..7).
- `hold_r`  in  1  R-stage stall.
- `hold_e`  in  1  E-stage stall.
- `flush`  in  1  kill R and E; reload OPTOP.
- `trap_in_progress`  in  1  trap frame being built.
- `arch_optop`  in  32  architectural OPTOP (reload source).
- `oplim`  in  32  stack limit; used only with the `PIPE_OPTOP_BOUND_CHK_EN` macro.
- `ready_r`  out  1  group accepted this cycle when `dec_valid_r` is also high.
- `optop_shft_r`  out  32  speculative OPTOP after the last accepted group; bits[1:0] are always 0.
- `pc_offset_r`  out  3  byte offset of the next group within the current 8-byte fetch word.
- `optop_sel_e`  out  4  one-hot select: [0] shft, [1] iu_data, [2] shadow, [3] const.
- `optop_enable`  out  3  optop pipe enables.
- `pc_enable`  out  3  pc pipe enables.
- `optop_ovf`  out  1  stack-limit violation pulse.

## Operation
- FSM states: RELOAD, RUN, TRAP. Reset enters RELOAD.
- Event priority: `reset` > `flush` > `trap_in_progress` > dispatch.
- RELOAD (exactly 1 cycle):
  - `optop_spec <= arch_optop & ~3`; `pc_offset <= 0`; `ready_r = 0`.
  - Next state is RUN. If `trap_in_progress` is high, next state is TRAP instead.
- RUN:
  - `ready_r = ~hold_r`.
  - On accept (`dec_valid_r & ready_r`): `optop_spec <= optop_spec − (sext(dec_delta_r) << 2)`, modulo 2^32.
  - On accept: `{carry, pc_offset} <= pc_offset + dec_len_r`. Carry = 1 pulses `pc_enable[0]` in the next cycle.
- TRAP:
  - `ready_r = 0`; `optop_sel_e = 4'b0100`.
  - On the cycle `trap_in_progress` falls, next state is RELOAD.
- `flush` in any state: next state RELOAD. Any dispatch in that same cycle is discarded.
- `optop_sel_e` by state:
  - RUN: 4'b0001.
  - RELOAD: 4'b0010.
  - TRAP: 4'b0100.
  - During reset: 4'b1000.
- Enables:
  - `optop_enable[0] = ~hold_e`.
  - `optop_enable[1] = ~hold_e & (state==RUN)`.
  - `optop_enable[2]` = 1-cycle pulse on the first TRAP cycle.
  - `pc_enable[0]` = fetch-word carry pulse, or RELOAD.
  - `pc_enable[1] = ~hold_e`.
  - `pc_enable[2] = ~hold_e & (state==RUN)`.
- Reset values:
  - `optop_shft_r = TRAP_OPTOP`; `pc_offset_r = 0`; `ready_r = 0`.
  - `optop_sel_e = 4'b1000`; all enables 0; `optop_ovf = 0`.

## Timing
- Group accepted in cycle n: `optop_shft_r` and `pc_offset_r` are updated in cycle n+1. Back-to-back accepts are allowed every cycle.
- `optop_shft_r` and `pc_offset_r` are registered.
- `ready_r`, `optop_sel_e` and the enables are combinational from state and holds; there is no path from `dec_*` to these outputs.
- Flush asserted in cycle n: RELOAD in n+1; first accept possible in n+2.
- `dec_len_r = 0`: `pc_offset` is unchanged and there is no carry.
- Offset 6 plus length 3: offset wraps to 1 and `pc_enable[0]` pulses.

## Configuration
- `PIPE_OPTOP_BOUND_CHK_EN` defined:
  - On accept, the new OPTOP is compared unsigned against `oplim`.
  - If new OPTOP < `oplim`, `optop_ovf` pulses for one cycle (registered, cycle n+1).
  - Dispatch is not blocked.
- `PIPE_OPTOP_BOUND_CHK_EN` undefined: `optop_ovf` is tied to 0, `oplim` is ignored, and no comparator is built.

## Structure
- Package `pipe_optop_pkg` holds:
  - the state enum (RELOAD/RUN/TRAP);
  - one-hot select constants SEL_SHFT/SEL_DATA/SEL_SHADOW/SEL_CONST;
  - the `TRAP_OPTOP` default and the `DELTA_W` default.
- Sub-module `pipe_optop_acc`: 32-bit OPTOP accumulator plus 3-bit offset adder with carry-out, with load and accept controls. The FSM and enable decoding stay in the top.

## Test plan
- Reset released with `arch_optop` = 0x1000 → first cycle after reset is RELOAD; the cycle after that `optop_shft_r` = 0x1000, `ready_r` = 1.
- Accept delta +2, then −1 → `optop_shft_r` = 0x0FF8, then 0x0FFC.
- `pc_offset` = 6, accept length 3 → `pc_offset_r` = 1 and `pc_enable[0]` pulses for one cycle.
- Flush in the same cycle as a valid group with delta +3, `arch_optop` = 0x2000 → group ignored; `optop_shft_r` = 0x2000 and `pc_offset_r` = 0 after RELOAD.
- `trap_in_progress` held high for 5 cycles → `ready_r` = 0, `optop_sel_e` = 4'b0100, `optop_enable[2]` pulses once; RELOAD follows deassertion.
- With the macro defined, `oplim` = 0x0FF0, `optop` = 0x0FF4, accept delta +2 → `optop_ovf` = 1 for one cycle and `optop_shft_r` = 0x0FEC.

Source files
------------

// File: rtl/pipe_optop_pkg.sv
// Shared types and constants for the R-stage OPTOP / PC-offset tracker.
// Optional stack-limit check: PIPE_OPTOP_BOUND_CHK_EN.
package pipe_optop_pkg;

  typedef enum logic [1:0] {
    ST_RELOAD = 2'd0,
    ST_RUN    = 2'd1,
    ST_TRAP   = 2'd2
  } state_e;

  localparam logic [3:0] SEL_SHFT   = 4'b0001;
  localparam logic [3:0] SEL_DATA   = 4'b0010;
  localparam logic [3:0] SEL_SHADOW = 4'b0100;
  localparam logic [3:0] SEL_CONST  = 4'b1000;

  localparam int unsigned DELTA_W_DEF    = 4;
  localparam logic [31:0] TRAP_OPTOP_DEF = 32'h003ffffc;

endpackage

// File: rtl/pipe_optop_acc.sv
// Speculative OPTOP accumulator and 3-bit fetch-word offset adder.
// Load wins over accept; carry is a one-cycle registered pulse.
module pipe_optop_acc
  import pipe_optop_pkg::*;
#(
  parameter int unsigned DELTA_W    = DELTA_W_DEF,
  parameter logic [31:0] TRAP_OPTOP = TRAP_OPTOP_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [31:0]        load_val,
  input  logic               accept,
  input  logic [DELTA_W-1:0] delta,
  input  logic [2:0]         len,
  output logic [31:0]        optop,
  output logic [2:0]         offset,
  output logic               carry,
  output logic [31:0]        optop_nxt
);

  logic [31:0] optop_q, optop_d;
  logic [2:0]  off_q, off_d;
  logic        carry_q, carry_d;
  logic [31:0] delta_ext;
  logic [3:0]  sum;

  always_comb begin
    delta_ext = {{(32-DELTA_W){delta[DELTA_W-1]}}, delta};
    // Positive delta pushes words, so the stack pointer moves down.
    optop_nxt = optop_q - (delta_ext << 2);
    sum       = {1'b0, off_q} + {1'b0, len};
    optop_d   = optop_q;
    off_d     = off_q;
    carry_d   = 1'b0;
    if (load) begin
      optop_d = {load_val[31:2], 2'b00};
      off_d   = 3'd0;
    end else if (accept) begin
      optop_d = optop_nxt;
      off_d   = sum[2:0];
      carry_d = sum[3];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      optop_q <= TRAP_OPTOP;
      off_q   <= 3'd0;
      carry_q <= 1'b0;
    end else begin
      optop_q <= optop_d;
      off_q   <= off_d;
      carry_q <= carry_d;
    end
  end

  assign optop  = optop_q;
  assign offset = off_q;
  assign carry  = carry_q;

endmodule

// File: rtl/pipe_optop_trk.sv
// R-stage speculative OPTOP / PC-offset tracker with flush/trap recovery.
// Define PIPE_OPTOP_BOUND_CHK_EN to build the oplim overflow pulse.
module pipe_optop_trk
  import pipe_optop_pkg::*;
#(
  parameter int unsigned DELTA_W    = DELTA_W_DEF,
  parameter logic [31:0] TRAP_OPTOP = TRAP_OPTOP_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               dec_valid_r,
  input  logic [DELTA_W-1:0] dec_delta_r,
  input  logic [2:0]         dec_len_r,
  input  logic               hold_r,
  input  logic               hold_e,
  input  logic               flush,
  input  logic               trap_in_progress,
  input  logic [31:0]        arch_optop,
  input  logic [31:0]        oplim,
  output logic               ready_r,
  output logic [31:0]        optop_shft_r,
  output logic [2:0]         pc_offset_r,
  output logic [3:0]         optop_sel_e,
  output logic [2:0]         optop_enable,
  output logic [2:0]         pc_enable,
  output logic               optop_ovf
);

  state_e      state_q, state_d;
  logic        tpulse_q, tpulse_d;
  logic        ready, load, accept, carry;
  logic [31:0] optop_nxt;

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    load    = 1'b0;
    case (state_q)
      ST_RELOAD: begin
        load    = 1'b1;
        state_d = trap_in_progress ? ST_TRAP : ST_RUN;
      end
      ST_RUN: begin
        ready = ~hold_r;
        if (trap_in_progress) state_d = ST_TRAP;
      end
      ST_TRAP: begin
        if (!trap_in_progress) state_d = ST_RELOAD;
      end
      default: state_d = ST_RELOAD;
    endcase
    if (flush) state_d = ST_RELOAD;
    // Flush and trap outrank dispatch even when ready_r is shown high.
    accept   = dec_valid_r & ready & ~flush & ~trap_in_progress;
    tpulse_d = (state_d == ST_TRAP) && (state_q != ST_TRAP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_RELOAD;
      tpulse_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tpulse_q <= tpulse_d;
    end
  end

  pipe_optop_acc #(
    .DELTA_W    (DELTA_W),
    .TRAP_OPTOP (TRAP_OPTOP)
  ) u_acc (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_val  (arch_optop),
    .accept    (accept),
    .delta     (dec_delta_r),
    .len       (dec_len_r),
    .optop     (optop_shft_r),
    .offset    (pc_offset_r),
    .carry     (carry),
    .optop_nxt (optop_nxt)
  );

  always_comb begin
    ready_r      = 1'b0;
    optop_sel_e  = SEL_CONST;
    optop_enable = 3'b000;
    pc_enable    = 3'b000;
    if (!reset) begin
      ready_r = ready;
      case (state_q)
        ST_RUN:    optop_sel_e = SEL_SHFT;
        ST_RELOAD: optop_sel_e = SEL_DATA;
        ST_TRAP:   optop_sel_e = SEL_SHADOW;
        default:   optop_sel_e = SEL_CONST;
      endcase
      optop_enable[0] = ~hold_e;
      optop_enable[1] = ~hold_e & (state_q == ST_RUN);
      optop_enable[2] = tpulse_q;
      pc_enable[0]    = carry | (state_q == ST_RELOAD);
      pc_enable[1]    = ~hold_e;
      pc_enable[2]    = ~hold_e & (state_q == ST_RUN);
    end
  end

`ifdef PIPE_OPTOP_BOUND_CHK_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = accept & (optop_nxt < oplim);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign optop_ovf = ovf_q;
`else
  logic unused_bound;
  assign unused_bound = ^{oplim, optop_nxt};
  assign optop_ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_optop_trk.sv
// Self-checking bench for pipe_optop_trk: directed scenarios plus a
// randomized run checked against an arithmetic reference model.
module tb_pipe_optop_trk;

  logic        clk;
  logic        reset;
  logic        dec_valid_r;
  logic [3:0]  dec_delta_r;
  logic [2:0]  dec_len_r;
  logic        hold_r, hold_e, flush, trap_in_progress;
  logic [31:0] arch_optop, oplim;
  logic        ready_r;
  logic [31:0] optop_shft_r;
  logic [2:0]  pc_offset_r;
  logic [3:0]  optop_sel_e;
  logic [2:0]  optop_enable, pc_enable;
  logic        optop_ovf;

  int n_cmp = 0;
  int n_err = 0;

`ifdef PIPE_OPTOP_BOUND_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  pipe_optop_trk dut (
    .clk              (clk),
    .reset            (reset),
    .dec_valid_r      (dec_valid_r),
    .dec_delta_r      (dec_delta_r),
    .dec_len_r        (dec_len_r),
    .hold_r           (hold_r),
    .hold_e           (hold_e),
    .flush            (flush),
    .trap_in_progress (trap_in_progress),
    .arch_optop       (arch_optop),
    .oplim            (oplim),
    .ready_r          (ready_r),
    .optop_shft_r     (optop_shft_r),
    .pc_offset_r      (pc_offset_r),
    .optop_sel_e      (optop_sel_e),
    .optop_enable     (optop_enable),
    .pc_enable        (pc_enable),
    .optop_ovf        (optop_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dec_valid_r      = 1'b0;
    dec_delta_r      = 4'd0;
    dec_len_r        = 3'd0;
    hold_r           = 1'b0;
    hold_e           = 1'b0;
    flush            = 1'b0;
    trap_in_progress = 1'b0;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    arch_optop = 32'h1000;
    oplim      = 32'h0;
    idle();
    tick();
    tick();
    n_cmp++;
    if (optop_shft_r !== 32'h003ffffc) begin
      n_err++;
      $display("FAIL rst_optop got %h want 003ffffc", optop_shft_r);
    end
    n_cmp++;
    if ({ready_r, pc_offset_r, optop_ovf} !== 5'b0) begin
      n_err++;
      $display("FAIL rst_misc got %b%b%b want 0",
               ready_r, pc_offset_r, optop_ovf);
    end
    n_cmp++;
    if (optop_sel_e !== 4'b1000) begin
      n_err++;
      $display("FAIL rst_sel got %b want 1000", optop_sel_e);
    end
    n_cmp++;
    if ({optop_enable, pc_enable} !== 6'b0) begin
      n_err++;
      $display("FAIL rst_en got %b %b want 0", optop_enable, pc_enable);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({ready_r, optop_sel_e} !== 5'b0_0010) begin
      n_err++;
      $display("FAIL reload_out got %b %b want 0 0010",
               ready_r, optop_sel_e);
    end
    n_cmp++;
    if (pc_enable !== 3'b011 || optop_enable !== 3'b001) begin
      n_err++;
      $display("FAIL reload_en got %b %b want 011 001",
               pc_enable, optop_enable);
    end
    tick();
    n_cmp++;
    if (optop_shft_r !== 32'h1000 || ready_r !== 1'b1) begin
      n_err++;
      $display("FAIL run_entry got %h %b want 00001000 1",
               optop_shft_r, ready_r);
    end
    n_cmp++;
    if (optop_sel_e !== 4'b0001) begin
      n_err++;
      $display("FAIL run_sel got %b want 0001", optop_sel_e);
    end
  endtask

  task automatic test_delta();
    dec_valid_r = 1'b1;
    dec_delta_r = 4'd2;
    tick();
    n_cmp++;
    if (optop_shft_r !== 32'h0FF8) begin
      n_err++;
      $display("FAIL delta_p2 got %h want 00000ff8", optop_shft_r);
    end
    dec_delta_r = 4'hF;
    tick();
    n_cmp++;
    if (optop_shft_r !== 32'h0FFC) begin
      n_err++;
      $display("FAIL delta_m1 got %h want 00000ffc", optop_shft_r);
    end
    dec_delta_r = 4'd3;
    hold_r      = 1'b1;
    #1;
    n_cmp++;
    if (ready_r !== 1'b0) begin
      n_err++;
      $display("FAIL hold_ready got %b want 0", ready_r);
    end
    tick();
    n_cmp++;
    if (optop_shft_r !== 32'h0FFC) begin
      n_err++;
      $display("FAIL hold_optop got %h want 00000ffc", optop_shft_r);
    end
    idle();
  endtask

  task automatic test_pc_carry();
    dec_valid_r = 1'b1;
    dec_len_r   = 3'd6;
    tick();
    n_cmp++;
    if (pc_offset_r !== 3'd6 || pc_enable[0] !== 1'b0) begin
      n_err++;
      $display("FAIL off6 got %0d %b want 6 0", pc_offset_r, pc_enable[0]);
    end
    dec_len_r = 3'd3;
    tick();
    n_cmp++;
    if (pc_offset_r !== 3'd1 || pc_enable[0] !== 1'b1) begin
      n_err++;
      $display("FAIL wrap got %0d %b want 1 1", pc_offset_r, pc_enable[0]);
    end
    dec_len_r = 3'd0;
    tick();
    n_cmp++;
    if (pc_offset_r !== 3'd1 || pc_enable[0] !== 1'b0) begin
      n_err++;
      $display("FAIL len0 got %0d %b want 1 0", pc_offset_r, pc_enable[0]);
    end
    idle();
  endtask

  task automatic test_flush();
    arch_optop  = 32'h2000;
    dec_valid_r = 1'b1;
    dec_delta_r = 4'd3;
    dec_len_r   = 3'd2;
    flush       = 1'b1;
    tick();
    idle();
    #1;
    n_cmp++;
    if (optop_shft_r !== 32'h0FFC || optop_sel_e !== 4'b0010) begin
      n_err++;
      $display("FAIL flush_drop got %h %b want 00000ffc 0010",
               optop_shft_r, optop_sel_e);
    end
    tick();
    n_cmp++;
    if (optop_shft_r !== 32'h2000 || pc_offset_r !== 3'd0) begin
      n_err++;
      $display("FAIL flush_reload got %h %0d want 00002000 0",
               optop_shft_r, pc_offset_r);
    end
    n_cmp++;
    if (ready_r !== 1'b1) begin
      n_err++;
      $display("FAIL flush_ready got %b want 1", ready_r);
    end
  endtask

  task automatic test_trap();
    int pulses;
    int bad;
    pulses = 0;
    bad    = 0;
    trap_in_progress = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 4) trap_in_progress = 1'b0;
      dec_valid_r = 1'b1;
      dec_delta_r = 4'd1;
      #1;
      if (optop_enable[2]) pulses++;
      if (ready_r !== 1'b0 || optop_sel_e !== 4'b0100) bad++;
      tick();
    end
    idle();
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL trap_out got %0d bad cycles want 0", bad);
    end
    n_cmp++;
    if (pulses != 1) begin
      n_err++;
      $display("FAIL trap_pulse got %0d want 1", pulses);
    end
    n_cmp++;
    if (optop_sel_e !== 4'b0010) begin
      n_err++;
      $display("FAIL trap_reload got %b want 0010", optop_sel_e);
    end
    tick();
    n_cmp++;
    if (optop_shft_r !== 32'h2000 || optop_sel_e !== 4'b0001) begin
      n_err++;
      $display("FAIL trap_exit got %h %b want 00002000 0001",
               optop_shft_r, optop_sel_e);
    end
  endtask

  task automatic test_bound();
    arch_optop = 32'h0FF4;
    oplim      = 32'h0FF0;
    flush      = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    dec_valid_r = 1'b1;
    dec_delta_r = 4'd2;
    tick();
    idle();
    n_cmp++;
    if (optop_shft_r !== 32'h0FEC || optop_ovf !== CHK) begin
      n_err++;
      $display("FAIL bound got %h %b want 00000fec %b",
               optop_shft_r, optop_ovf, CHK);
    end
    tick();
    n_cmp++;
    if (optop_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL bound_pulse got %b want 0", optop_ovf);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_optop;
    logic [31:0] nxt;
    int          exp_off;
    int          sd;
    int          sum;
    bit          acc;
    bit          exp_c;
    bit          exp_v;
    int          errs;
    errs       = 0;
    arch_optop = $urandom;
    flush      = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    exp_optop = arch_optop & 32'hFFFF_FFFC;
    exp_off   = 0;
    for (int i = 0; i < 300; i++) begin
      dec_valid_r = 1'($urandom_range(0, 1));
      dec_delta_r = 4'($urandom_range(0, 15));
      dec_len_r   = 3'($urandom_range(0, 7));
      hold_r      = ($urandom_range(0, 3) == 0);
      hold_e      = ($urandom_range(0, 3) == 0);
      oplim       = exp_optop + 32'($urandom_range(0, 64)) - 32'd32;
      #1;
      n_cmp++;
      if (ready_r !== !hold_r ||
          optop_enable !== {1'b0, !hold_e, !hold_e} ||
          pc_enable[2:1] !== {!hold_e, !hold_e}) begin
        n_err++;
        errs++;
        if (errs < 10)
          $display("FAIL rnd_comb cyc %0d got %b %b %b", i,
                   ready_r, optop_enable, pc_enable);
      end
      acc   = dec_valid_r && !hold_r;
      sd    = (dec_delta_r >= 8) ? int'(dec_delta_r) - 16
                                 : int'(dec_delta_r);
      nxt   = exp_optop - 32'(sd * 4);
      exp_c = 1'b0;
      exp_v = 1'b0;
      if (acc) begin
        sum       = exp_off + int'(dec_len_r);
        exp_c     = (sum >= 8);
        exp_off   = sum % 8;
        exp_v     = CHK && (nxt < oplim);
        exp_optop = nxt;
      end
      tick();
      n_cmp++;
      if (optop_shft_r !== exp_optop || pc_offset_r !== 3'(exp_off) ||
          pc_enable[0] !== exp_c || optop_ovf !== exp_v) begin
        n_err++;
        errs++;
        if (errs < 10)
          $display("FAIL rnd_state cyc %0d got %h %0d %b %b want %h %0d %b %b",
                   i, optop_shft_r, pc_offset_r, pc_enable[0], optop_ovf,
                   exp_optop, exp_off, exp_c, exp_v);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_delta();
    test_pc_carry();
    test_flush();
    test_trap();
    test_bound();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
